rf_writeback: RTL

Write-side front end for the RISC-16 register file: accepts destination-register results from the ALU and load paths over valid/ready handshakes, buffers them in a small FIFO, and drains them one per cycle onto the register file write port (`reg_wr`, `addr_Rz`, `write_data`). Sits between the execute/memory stages and `REGISTER_FILE`. Decouples producer bursts from the single write port and optionally forwards pending results to the operand read ports.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_wb_fifo.sv | 39 +++
 rtl/rf_writeback.sv | 106 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, R0 address and write-back entry type for the register file write path.
package rf_pkg;
   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 4;
   localparam logic [RF_ADDR_W-1:0] R0 = '0;
   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: write-back entry FIFO with occupancy count; storage is exposed for forward lookup.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  wb_entry_t                  din,
   output wb_entry_t                  head,
   output wb_entry_t                  ents [DEPTH],
   output logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   wb_entry_t mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   assign head  = mem[rd_ptr];
   assign ents  = mem;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
         count  <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates load/ALU results into a FIFO and drains one register write per cycle.
// Define RF_WB_FWD_EN to enable forwarding of pending writes to the operand read ports.
module rf_writeback
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] addr_Rz,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] addr_Rx,
   input  logic [ADDR_W-1:0] addr_Ry,
   output logic              fwd_Rx_hit,
   output logic [DATA_W-1:0] fwd_Rx_data,
   output logic              fwd_Ry_hit,
   output logic [DATA_W-1:0] fwd_Ry_data,
   output logic              wb_idle
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   wb_entry_t din, head;
   wb_entry_t ents [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic full, empty, push, ld_fire, alu_fire;
   assign ld_ready  = ~full & ~reset;
   assign alu_ready = ~full & ~ld_valid & ~reset;
   assign ld_fire   = ld_valid & ld_ready;
   assign alu_fire  = alu_valid & alu_ready;
   assign din       = ld_fire ? wb_entry_t'({ld_addr, ld_data}) : wb_entry_t'({alu_addr, alu_data});
   // R0 writes complete the handshake but never reach the register file
   assign push      = (ld_fire & (ld_addr != ADDR_W'(R0))) | (alu_fire & (alu_addr != ADDR_W'(R0)));
   assign wb_idle   = empty & ~reg_wr;
   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .pop    (~empty),
      .din    (din),
      .head   (head),
      .ents   (ents),
      .rd_ptr (rd_ptr),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_wr     <= 1'b0;
         addr_Rz    <= '0;
         write_data <= '0;
      end else begin
         reg_wr     <= ~empty;
         addr_Rz    <= empty ? addr_Rz : head.addr;
         write_data <= empty ? write_data : head.data;
      end
   end
`ifdef RF_WB_FWD_EN
   for (genvar q = 0; q < 2; q++) begin : g_fwd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] data;
      logic [PW-1:0] idx;
      logic hit;
      assign a = (q == 0) ? addr_Rx : addr_Ry;
      // scan oldest to newest so the newest match overwrites older ones
      always_comb begin
         hit  = reg_wr && addr_Rz == a && a != ADDR_W'(R0);
         data = hit ? write_data : '0;
         idx  = '0;
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count && ents[idx].addr == a && a != ADDR_W'(R0)) begin
               hit  = 1'b1;
               data = ents[idx].data;
            end
         end
      end
   end
   assign fwd_Rx_hit  = g_fwd[0].hit;
   assign fwd_Rx_data = g_fwd[0].data;
   assign fwd_Ry_hit  = g_fwd[1].hit;
   assign fwd_Ry_data = g_fwd[1].data;
`else
   logic unused_fwd;
   always_comb begin
      unused_fwd = ^{addr_Rx, addr_Ry, rd_ptr, count};
      for (int i = 0; i < DEPTH; i++) unused_fwd = unused_fwd ^ (^ents[i]);
   end
   assign fwd_Rx_hit  = 1'b0;
   assign fwd_Rx_data = '0;
   assign fwd_Ry_hit  = 1'b0;
   assign fwd_Ry_data = '0;
`endif
endmodule
